// File: rtl/led_pattern_gen.sv
// LED pattern generator: a programmable-rate terminal counter drives OFF, BLINK,
// CHASE and BOUNCE patterns on NUM_LEDS outputs, with pause and a tick pulse.
module led_pattern_gen #(
  parameter int CNT_W    = 28,
  parameter int NUM_LEDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          key,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);

  typedef enum logic [1:0] {
    M_OFF    = 2'b00,
    M_BLINK  = 2'b01,
    M_CHASE  = 2'b10,
    M_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                on_q, on_d;
  logic [NUM_LEDS-1:0] onehot_q, onehot_d;
  dir_e                dir_q, dir_d;
  mode_e               mode_q, mode_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                tick_q, tick_d;

  logic [CNT_W-1:0]    tc;
  logic                mode_chg;
  logic                term;
  logic                unused_key;

  assign unused_key = ^key[6:5];
  assign tc         = CNT_MAX >> key[4:2];
  assign mode_chg   = (key[1:0] != mode_q);

  always_comb begin
    cnt_d    = cnt_q;
    on_d     = on_q;
    onehot_d = onehot_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    term     = 1'b0;
    led_d    = led_q;

    if (mode_chg) begin
      cnt_d    = '0;
      on_d     = 1'b0;
      onehot_d = NUM_LEDS'(1);
      dir_d    = DIR_LEFT;
      mode_d   = mode_e'(key[1:0]);
    end else if (!key[7]) begin
      // ">=" lets a speed-up below the current count terminate at once
      if (cnt_q >= tc) begin
        cnt_d = '0;
        term  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      tick_d = term;

      if (term) begin
        case (mode_q)
          M_BLINK: on_d = ~on_q;
          M_CHASE: onehot_d = {onehot_q[NUM_LEDS-2:0], onehot_q[NUM_LEDS-1]};
          M_BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              onehot_d = {onehot_q[NUM_LEDS-2:0], 1'b0};
              if (onehot_d[NUM_LEDS-1]) dir_d = DIR_RIGHT;
            end else begin
              onehot_d = {1'b0, onehot_q[NUM_LEDS-1:1]};
              if (onehot_d[0]) dir_d = DIR_LEFT;
            end
          end
          default: ;
        endcase
      end
    end

    // LED image follows the next pattern state so it lands together with tick
    case (mode_d)
      M_OFF:   led_d = '0;
      M_BLINK: led_d = {NUM_LEDS{on_d}};
      default: led_d = onehot_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      on_q     <= 1'b0;
      onehot_q <= NUM_LEDS'(1);
      dir_q    <= DIR_LEFT;
      mode_q   <= M_OFF;
      led_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      on_q     <= on_d;
      onehot_q <= onehot_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      tick_q   <= tick_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (CNT_W=4, NUM_LEDS=4): expected ticks are
// queued by the driver with their cycle and LED value; a monitor pops on each tick.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic [7:0] key;
  logic [3:0] led;
  logic       tick;

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;

  typedef struct {
    int         at;
    logic [3:0] led;
  } exp_t;

  exp_t sb[$];

  led_pattern_gen #(.CNT_W(4), .NUM_LEDS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .led  (led),
    .tick (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int at, input logic [3:0] l);
    exp_t e;
    e.at  = at;
    e.led = l;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every tick must match the oldest queued expectation
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tick_cycle", 32'(cyc), 32'(e.at));
        check("tick_led", 32'(led), 32'(e.led));
      end
    end
  end

  initial begin
    int p, q, r, s;
    rst = 1'b0;
    key = 8'h00;

    goto(3);
    check("reset_led", 32'(led), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);

    // BLINK, s=0: period 16 after mode registers
    p = cyc;
    rst = 1'b1;
    key = 8'h01;
    push(p + 17, 4'b1111);
    push(p + 33, 4'b0000);
    push(p + 49, 4'b1111);

    // Pause 10 cycles at cnt=5: next tick slips by exactly 10
    goto(p + 54);
    key = 8'h81;
    goto(p + 60);
    check("pause_led_frozen", 32'(led), 32'hF);
    goto(p + 64);
    key = 8'h01;
    push(p + 75, 4'b0000);

    // CHASE, s=2 (TC=3)
    goto(p + 76);
    q = cyc;
    key = 8'h0A;
    goto(q + 1);
    check("chase_init_led", 32'(led), 32'h1);
    push(q + 5,  4'b0010);
    push(q + 9,  4'b0100);
    push(q + 13, 4'b1000);
    push(q + 17, 4'b0001);
    push(q + 21, 4'b0010);
    push(q + 25, 4'b0100);

    // Mode change 10->01 while led=0100, then reset pulse mid-period
    goto(q + 26);
    key = 8'h01;
    goto(q + 27);
    check("modechg_led", 32'(led), 32'h0);
    goto(q + 30);
    rst = 1'b0;
    goto(q + 31);
    check("midreset_led", 32'(led), 32'h0);
    check("midreset_tick", 32'(tick), 32'h0);
    goto(q + 32);
    rst = 1'b1;

    // Speed change s=0->3 at cnt=9: immediate terminal, then period 2
    goto(q + 42);
    key = 8'h0D;
    push(q + 43, 4'b1111);
    push(q + 45, 4'b0000);
    push(q + 47, 4'b1111);

    // BOUNCE, s=3 (TC=1)
    goto(q + 48);
    r = cyc;
    key = 8'h0F;
    goto(r + 1);
    check("bounce_init_led", 32'(led), 32'h1);
    push(r + 3,  4'b0010);
    push(r + 5,  4'b0100);
    push(r + 7,  4'b1000);
    push(r + 9,  4'b0100);
    push(r + 11, 4'b0010);
    push(r + 13, 4'b0001);
    push(r + 15, 4'b0010);

    // OFF, s=3: ticks continue with dark LEDs
    goto(r + 16);
    s = cyc;
    key = 8'h0C;
    goto(s + 1);
    check("off_led", 32'(led), 32'h0);
    push(s + 3, 4'b0000);
    push(s + 5, 4'b0000);

    goto(s + 6);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
